fifo_rd_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_rd_packer_timer.sv | 20 ++
 rtl/fifo_rd_packer.sv | 101 ++++++++++
 tb/tb_fifo_rd_packer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared packer state encoding and keep-mask helper
package fifo_pkg;
  typedef enum logic {FILL, FLUSH} packer_state_e;
  function automatic logic [31:0] keep_mask(input logic [31:0] cnt, input int unsigned ratio);
    logic [31:0] n;
    n = (cnt >= ratio) ? ratio : cnt;
    return (n >= 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction
endpackage

// File: rtl/fifo_rd_packer_timer.sv
// fifo_rd_packer_timer: idle counter that flags expiry after TIMEOUT-1 counted cycles
module fifo_rd_packer_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] count_q, count_d;
  assign expired = count_q == TW'(TIMEOUT - 1);
  // count idle cycles, holding at the expiry value until cleared
  always_comb count_d = clear ? '0 : (count_en && !expired) ? count_q + 1'b1 : count_q;
  // idle counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs RATIO FIFO words into keep-masked beats; FIFO_RD_PACKER_TIMEOUT_EN adds idle auto-flush
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_rd_data,
  output logic                   fifo_rd,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   busy
);
  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  packer_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RATIO-1:0][WIDTH-1:0] acc_q, acc_d, m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic m_valid_q, m_valid_d, flush_q, out_free, pop, auto_flush;
  assign out_free = !m_valid_q || m_ready;
  assign pop = rd_rst_n && state_q == FILL && !fifo_empty && (cnt_q < LAST || out_free);
  assign fifo_rd = pop;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_keep = m_keep_q;
  assign busy = cnt_q != '0 || m_valid_q || flush_q || state_q == FLUSH;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  logic idle, expired;
  assign idle = state_q == FILL && cnt_q != '0 && fifo_empty;
  fifo_rd_packer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .clear    (pop || state_q == FLUSH),
    .count_en (idle),
    .expired  (expired)
  );
  assign auto_flush = expired && idle;
`else
  assign auto_flush = TIMEOUT < 0;
`endif
  // accumulate pops, hand full or flushed beats to the output register, sequence FILL/FLUSH
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_data_d = m_data_q;
    m_keep_d = m_keep_q;
    m_valid_d = m_valid_q && !m_ready;
    if (state_q == FILL) begin
      if (pop && cnt_q == LAST) begin
        m_data_d = acc_q;
        m_data_d[RATIO-1] = fifo_rd_data;
        m_keep_d = '1;
        m_valid_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else if (pop) begin
        acc_d[cnt_q[IW-1:0]] = fifo_rd_data;
        cnt_d = cnt_q + 1'b1;
      end
      if (flush_q || auto_flush) state_d = FLUSH;
    end else if (cnt_q == '0) begin
      state_d = FILL;
    end else if (out_free) begin
      m_data_d = acc_q;
      m_keep_d = RATIO'(keep_mask(32'(cnt_q), RATIO));
      m_valid_d = 1'b1;
      acc_d = '0;
      cnt_d = '0;
      state_d = FILL;
    end
  end
  // state, accumulator and output registers; flush is registered and ignored while flushing
  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      state_q <= FILL;
      cnt_q <= '0;
      acc_q <= '0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_data_q <= m_data_d;
      m_keep_q <= m_keep_d;
      m_valid_q <= m_valid_d;
      flush_q <= flush && state_q == FILL;
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed table and sequence checks for fifo_rd_packer (WIDTH=8, RATIO=4)
module tb_fifo_rd_packer;
  logic clk = 1'b0, rd_rst_n = 1'b0, fifo_empty, fifo_rd, flush = 1'b0;
  logic m_valid, m_ready = 1'b0, busy;
  logic [7:0] fifo_rd_data;
  logic [31:0] m_data;
  logic [3:0] m_keep;
  logic [7:0] mem [64];
  int rd_idx = 0, wr_idx = 0, errors = 0, checks = 0, base;
  bit seen;
  typedef struct {
    logic ready; logic flush; logic rd; logic valid; logic [31:0] data; logic [3:0] keep; logic busy;
  } vec_t;
  vec_t tbl [10];

  fifo_rd_packer dut (
    .rd_clk(clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd(fifo_rd), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .busy(busy)
  );

  always #5 clk = ~clk;
  assign fifo_empty = rd_idx == wr_idx;
  assign fifo_rd_data = mem[rd_idx % 64];
  always @(posedge clk) if (fifo_rd) rd_idx <= rd_idx + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push(input logic [7:0] w);
    mem[wr_idx % 64] = w;
    wr_idx++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'hF, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'hF, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h44332211, 4'hF, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'hF, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00000055, 4'h1, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000055, 4'h1, 1'b0};
    cyc();
    cyc();
    chk("reset_valid", 32'(m_valid), 0);
    chk("reset_data", m_data, 0);
    chk("reset_keep", 32'(m_keep), 0);
    chk("reset_busy", 32'(busy), 0);
    rd_rst_n = 1'b1;
    foreach (tbl[i]) if (i < 5) push(8'(8'h11 * (i + 1)));
    for (int i = 0; i < 10; i++) begin
      m_ready = tbl[i].ready;
      flush = tbl[i].flush;
      cyc();
      chk($sformatf("tbl%0d_rd", i), 32'(fifo_rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
      chk($sformatf("tbl%0d_keep", i), 32'(m_keep), 32'(tbl[i].keep));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    flush = 1'b0;
    m_ready = 1'b0;
    base = rd_idx;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (10) cyc();
    chk("bp_pops", 32'(rd_idx - base), 7);
    chk("bp_rd_blocked", 32'(fifo_rd), 0);
    chk("bp_valid_held", 32'(m_valid), 1);
    chk("bp_data_held", m_data, 32'h04030201);
    m_ready = 1'b1;
    #1;
    chk("bp_rd_release", 32'(fifo_rd), 1);
    cyc();
    chk("bp_second_data", m_data, 32'h08070605);
    chk("bp_second_valid", 32'(m_valid), 1);
    chk("bp_pops_total", 32'(rd_idx - base), 8);
    cyc();
    chk("bp_drain_valid", 32'(m_valid), 0);
    chk("bp_drain_busy", 32'(busy), 0);
    for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i));
    repeat (3) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fc_valid", 32'(m_valid), 1);
    chk("fc_data", m_data, 32'hA4A3A2A1);
    chk("fc_keep", 32'(m_keep), 32'hF);
    cyc();
    chk("fc_flush_valid", 32'(m_valid), 0);
    chk("fc_flush_busy", 32'(busy), 1);
    cyc();
    chk("fc_exit_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("fc_no_extra%0d", i), 32'(m_valid), 0);
    end
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(8'hC0 + i));
    repeat (6) cyc();
    chk("rst_pre_valid", 32'(m_valid), 1);
    chk("rst_pre_data", m_data, 32'hC4C3C2C1);
    for (int i = 1; i <= 4; i++) push(8'(8'hD0 + i));
    base = rd_idx;
    rd_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(m_valid), 0);
    chk("rst_mid_keep", 32'(m_keep), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_rd", 32'(fifo_rd), 0);
    cyc();
    chk("rst_no_pop", 32'(rd_idx - base), 0);
    rd_rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_clean_early", 32'(m_valid), 0);
    cyc();
    chk("rst_clean_valid", 32'(m_valid), 1);
    chk("rst_clean_data", m_data, 32'hD4D3D2D1);
    chk("rst_clean_keep", 32'(m_keep), 32'hF);
    cyc();
    push(8'hE1);
    seen = 1'b0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      seen = m_valid;
    end
    chk("to_beat_seen", 32'(seen), 1);
    chk("to_beat_keep", 32'(m_keep), 32'h1);
    chk("to_beat_data", m_data, 32'h000000E1);
`else
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (m_valid) seen = 1'b1;
    end
    chk("no_auto_flush", 32'(seen), 0);
    chk("no_auto_busy", 32'(busy), 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    chk("fl2_latency", 32'(m_valid), 0);
    cyc();
    chk("fl2_valid", 32'(m_valid), 1);
    chk("fl2_keep", 32'(m_keep), 32'h1);
    chk("fl2_data", m_data, 32'h000000E1);
`endif
    cyc();
    chk("final_idle", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
